bsg_cgol_enc_ctrl: RTL and testbench



---
 rtl/bsg_cgol_enc_ctrl.sv | 104 ++++++++++
 tb/tb_bsg_cgol_enc_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bsg_cgol_enc_ctrl.sv
// Encrypt-side control for the Arnold's Cat Map engine.
// Valid/ready: an input transfers on a cycle where ready_o and v_i are both
// high; a result transfers on a cycle where v_o and yumi_i are both high.
// The requested count F is reduced modulo period_p by repeated subtraction.
// The cell array is then stepped r = F mod period_p times, and r is presented
// as the key.
module bsg_cgol_enc_ctrl #(
   parameter int board_width_p     = 16,
   parameter int max_game_length_p = 63,
   parameter int period_p          = 12,
   localparam int game_len_width_lp =
      ((max_game_length_p + 1) <= 1) ? 1 : $clog2(max_game_length_p + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         en_i,
   input  logic [game_len_width_lp-1:0] frames_i,
   input  logic                         v_i,
   output logic                         ready_o,
   output logic [game_len_width_lp-1:0] key_o,
   output logic                         v_o,
   input  logic                         yumi_i,
   output logic                         update_o,
   output logic                         en_o
);

   typedef enum logic [1:0] {
      eWAIT   = 2'd0,
      eREDUCE = 2'd1,
      eRUN    = 2'd2,
      eDONE   = 2'd3
   } state_e;

   // Only consumed by a subtraction guarded by rem_r >= period_p, so the
   // truncation is harmless when period_p exceeds the counter range.
   localparam logic [game_len_width_lp-1:0] period_w = game_len_width_lp'(period_p);

   state_e                       state_r, state_n;
   logic [game_len_width_lp-1:0] rem_r, rem_n;
   logic [game_len_width_lp-1:0] run_r, run_n;

   // en_i is a clock-gating hook, and board_width_p is informational only.
   logic        unused_en;
   logic [31:0] unused_board;
   assign unused_en    = en_i;
   assign unused_board = 32'(board_width_p);

   // State register; reset abandons any run in progress.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_r <= eWAIT;
      else         state_r <= state_n;
   end

   // Remainder and run counter are not reset; they are always loaded before use.
   always_ff @(posedge clk_i) begin
      rem_r <= rem_n;
      run_r <= run_n;
   end

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_n  = state_r;
      rem_n    = rem_r;
      run_n    = run_r;
      ready_o  = 1'b0;
      update_o = 1'b0;
      en_o     = 1'b0;
      v_o      = 1'b0;
      key_o    = rem_r;
      case (state_r)
         eWAIT: begin
            ready_o  = 1'b1;
            update_o = v_i;
            if (v_i) begin
               rem_n   = frames_i;
               state_n = eREDUCE;
            end
         end
         eREDUCE: begin
            // The compare runs at 32 bits so that a period longer than any
            // legal count simply falls through to the run/done decision.
            if (32'(rem_r) >= $unsigned(period_p)) begin
               rem_n = rem_r - period_w;
            end else if (rem_r == '0) begin
               state_n = eDONE;
            end else begin
               run_n   = rem_r;
               state_n = eRUN;
            end
         end
         eRUN: begin
            en_o  = 1'b1;
            run_n = run_r - 1'b1;
            if (run_r == game_len_width_lp'(1)) state_n = eDONE;
         end
         eDONE: begin
            v_o = 1'b1;
            if (yumi_i) state_n = eWAIT;
         end
         default: state_n = eWAIT;
      endcase
   end

endmodule

// File: tb/tb_bsg_cgol_enc_ctrl.sv
// Testbench for bsg_cgol_enc_ctrl with period 12 and counts of 0..63.
module tb_bsg_cgol_enc_ctrl;

   localparam int P  = 12;
   localparam int MF = 63;
   localparam int W  = 6;

   logic         clk = 1'b0;
   logic         reset_i = 1'b1;
   logic         en_i = 1'b0;
   logic [W-1:0] frames_i = '0;
   logic         v_i = 1'b0;
   logic         ready_o;
   logic [W-1:0] key_o;
   logic         v_o;
   logic         yumi_i = 1'b0;
   logic         update_o;
   logic         en_o;

   int total = 0;
   int bad   = 0;

   bsg_cgol_enc_ctrl #(
      .board_width_p(16),
      .max_game_length_p(MF),
      .period_p(P)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .en_i(en_i),
      .frames_i(frames_i),
      .v_i(v_i),
      .ready_o(ready_o),
      .key_o(key_o),
      .v_o(v_o),
      .yumi_i(yumi_i),
      .update_o(update_o),
      .en_o(en_o)
   );

   // Clock
   always #5 clk = ~clk;

   typedef struct {
      int frames;
      int hold;
      int exp_key;
      int exp_red;
      int exp_run;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flags packed as {ready, en, v, update}.
   function automatic logic [3:0] flags();
      return {ready_o, en_o, v_o, update_o};
   endfunction

   // One complete transaction starting at a negedge in the idle state.
   task automatic do_txn(input int f, input int hold, input int exp_key,
                         input int exp_red, input int exp_run);
      check("idle_flags", 32'(flags()), 32'b1000);
      v_i = 1'b1;
      frames_i = W'(f);
      #1;
      check("accept_update", 32'(update_o), 32'd1);
      @(negedge clk);
      for (int k = 0; k < exp_red; k++) begin
         v_i = 1'($urandom_range(0, 1));
         #1;
         check("reduce_flags", 32'(flags()), 32'b0000);
         @(negedge clk);
      end
      for (int k = 0; k < exp_run; k++) begin
         v_i = 1'($urandom_range(0, 1));
         #1;
         check("run_flags", 32'(flags()), 32'b0100);
         @(negedge clk);
      end
      for (int k = 0; k < hold; k++) begin
         yumi_i = 1'b0;
         v_i = 1'($urandom_range(0, 1));
         #1;
         check("wait_flags", 32'(flags()), 32'b0010);
         check("wait_key", 32'(key_o), 32'(exp_key));
         @(negedge clk);
      end
      yumi_i = 1'b1;
      v_i = 1'b0;
      #1;
      check("yumi_flags", 32'(flags()), 32'b0010);
      check("yumi_key", 32'(key_o), 32'(exp_key));
      @(negedge clk);
      yumi_i = 1'b0;
      check("ready_again", 32'(flags()), 32'b1000);
   endtask

   initial begin
      // Hand-computed expectations for period 12.
      vecs[0] = '{frames: 5,  hold: 0,  exp_key: 5,  exp_red: 1, exp_run: 5};
      vecs[1] = '{frames: 29, hold: 0,  exp_key: 5,  exp_red: 3, exp_run: 5};
      vecs[2] = '{frames: 12, hold: 0,  exp_key: 0,  exp_red: 2, exp_run: 0};
      vecs[3] = '{frames: 0,  hold: 0,  exp_key: 0,  exp_red: 1, exp_run: 0};
      vecs[4] = '{frames: 11, hold: 10, exp_key: 11, exp_red: 1, exp_run: 11};
      vecs[5] = '{frames: 63, hold: 2,  exp_key: 3,  exp_red: 6, exp_run: 3};
      vecs[6] = '{frames: 24, hold: 1,  exp_key: 0,  exp_red: 3, exp_run: 0};
      vecs[7] = '{frames: 13, hold: 10, exp_key: 1,  exp_red: 2, exp_run: 1};

      // Reset
      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      check("reset_flags", 32'(flags()), 32'b1000);

      for (int i = 0; i < 8; i++)
         do_txn(vecs[i].frames, vecs[i].hold, vecs[i].exp_key,
                vecs[i].exp_red, vecs[i].exp_run);

      // Reset on the third run cycle of F=7 abandons the run.
      check("pre_rst_idle", 32'(flags()), 32'b1000);
      v_i = 1'b1;
      frames_i = W'(7);
      @(negedge clk);
      v_i = 1'b0;
      check("rst_reduce", 32'(flags()), 32'b0000);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_run", 32'(flags()), 32'b0100);
         if (k == 2) reset_i = 1'b1;
         @(negedge clk);
      end
      check("rst_abandon", 32'(flags()), 32'b1000);
      reset_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rst_quiet", 32'(flags()), 32'b1000);
      end
      do_txn(7, 0, 7, 1, 7);

      // Randomized counts against the modulo model.
      for (int i = 0; i < 25; i++) begin
         int f;
         f = int'($urandom_range(0, MF));
         do_txn(f, int'($urandom_range(0, 3)), f % P, f / P + 1, f % P);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
